ugv_motion_sequencer: RTL and testbench

//   Sequences motion commands for the UGV motor-driver PWM stage. Accepts speed/direction

---
 rtl/ugv_motion_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_ugv_motion_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ugv_motion_sequencer.sv
// ugv_motion_sequencer: motion-command sequencer for the UGV H-bridge PWM stage.
// Ramps the shared duty word towards the commanded speed, brakes to zero and
// inserts dead time before any direction change, and auto-stops on command silence.
module ugv_motion_sequencer #(
    parameter int unsigned RAMP_DIV    = 1000,
    parameter int unsigned RAMP_STEP   = 4,
    parameter int unsigned DEADTIME    = 5000,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_speed,
    input  logic [1:0] cmd_dir,
    output logic [7:0] duty,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       in4,
    output logic       busy,
    output logic       wdog_trip
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_RUN,
        S_BRAKE,
        S_DEAD
    } state_t;

    localparam logic [1:0]  DIR_STOP  = 2'b00;
    localparam logic [7:0]  STEP8     = 8'(RAMP_STEP);
    localparam logic [31:0] DIV_LAST  = 32'(RAMP_DIV - 1);
    localparam logic [31:0] DEAD_LAST = 32'(DEADTIME - 1);
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    localparam bit          WDOG_EN   = (WDOG_CYCLES != 0);

    state_t      state_q, state_d;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  target_q, target_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pend_dir_q, pend_dir_d;
    logic [7:0]  pend_speed_q, pend_speed_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] dead_q, dead_d;
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_trip_q, wdog_trip_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic [3:0]  pins_q, pins_d;

    logic accept;
    logic moving;
    logic ramping;
    logic tick;
    logic trip;

    function automatic logic [3:0] pin_map(input logic [1:0] d);
        case (d)
            2'b01:   return 4'b1010;
            2'b10:   return 4'b0110;
            2'b11:   return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Saturating step towards tgt; comparing the remaining gap against the step
    // gives the same result as 9-bit add/subtract with clamping, without a carry bit.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] r;
        r = cur;
        if (cur < tgt) begin
            r = ((tgt - cur) <= STEP8) ? tgt : cur + STEP8;
        end else if (cur > tgt) begin
            r = ((cur - tgt) <= STEP8) ? tgt : cur - STEP8;
        end
        return r;
    endfunction

    // Next-state computation: ramping, dead time, watchdog, then command acceptance
    // (an accept or watchdog trip overrides any ramp step due on the same clock).
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        target_d     = target_q;
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_speed_d = pend_speed_q;
        dead_d       = dead_q;
        wdog_d       = wdog_q;
        wdog_trip_d  = wdog_trip_q;
        presc_d      = '0;
        trip         = 1'b0;

        accept  = cmd_valid & cmd_ready_q;
        moving  = ((state_q == S_RAMP) || (state_q == S_RUN)) && (dir_q != DIR_STOP);
        ramping = (state_q == S_RAMP) || (state_q == S_BRAKE);
        tick    = ramping && (presc_q == DIV_LAST);

        if (tick) begin
            duty_d = ramp_step(duty_q, target_q);
        end

        if (accept) begin
            wdog_d = '0;
        end else if (WDOG_EN && moving) begin
            if (wdog_q == WDOG_LAST) begin
                trip   = 1'b1;
                wdog_d = '0;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end else begin
            wdog_d = '0;
        end

        case (state_q)
            S_RAMP: begin
                if (duty_d == target_q) begin
                    state_d = S_RUN;
                end
            end
            S_BRAKE: begin
                if (duty_d == '0) begin
                    state_d = S_DEAD;
                    dir_d   = DIR_STOP;
                    dead_d  = '0;
                end
            end
            S_DEAD: begin
                if (dead_q == DEAD_LAST) begin
                    dead_d = '0;
                    if (pend_dir_q == DIR_STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        dir_d    = pend_dir_q;
                        target_d = pend_speed_q;
                        state_d  = (pend_speed_q == '0) ? S_RUN : S_RAMP;
                    end
                end else begin
                    dead_d = dead_q + 32'd1;
                end
            end
            default: ;
        endcase

        if (accept) begin
            wdog_trip_d = 1'b0;
            duty_d      = duty_q;
            if (cmd_dir == DIR_STOP) begin
                pend_dir_d = DIR_STOP;
                target_d   = '0;
                state_d    = S_BRAKE;
            end else if (cmd_dir == dir_q) begin
                target_d = cmd_speed;
                state_d  = (duty_q == cmd_speed) ? S_RUN : S_RAMP;
            end else if ((dir_q == DIR_STOP) && (duty_q == '0)) begin
                dir_d    = cmd_dir;
                target_d = cmd_speed;
                state_d  = S_RAMP;
            end else begin
                pend_dir_d   = cmd_dir;
                pend_speed_d = cmd_speed;
                target_d     = '0;
                state_d      = S_BRAKE;
            end
        end else if (trip) begin
            wdog_trip_d = 1'b1;
            duty_d      = duty_q;
            pend_dir_d  = DIR_STOP;
            target_d    = '0;
            state_d     = S_BRAKE;
        end

        // The prescaler restarts on every state entry and on every accepted command.
        if ((state_d == state_q) && ramping && !accept && !trip) begin
            presc_d = tick ? '0 : presc_q + 32'd1;
        end

        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_RAMP) || (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
        pins_d      = pin_map(dir_d);
    end

    // State and registered outputs; asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            duty_q       <= '0;
            target_q     <= '0;
            dir_q        <= '0;
            pend_dir_q   <= '0;
            pend_speed_q <= '0;
            presc_q      <= '0;
            dead_q       <= '0;
            wdog_q       <= '0;
            wdog_trip_q  <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            pins_q       <= '0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            target_q     <= target_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_speed_q <= pend_speed_d;
            presc_q      <= presc_d;
            dead_q       <= dead_d;
            wdog_q       <= wdog_d;
            wdog_trip_q  <= wdog_trip_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            pins_q       <= pins_d;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign duty               = duty_q;
    assign {in1, in2, in3, in4} = pins_q;
    assign busy               = busy_q;
    assign wdog_trip          = wdog_trip_q;

endmodule

// File: tb/tb_ugv_motion_sequencer.sv
// tb_ugv_motion_sequencer: trajectory-planning reference model feeding a per-cycle
// scoreboard, driven by directed scenarios followed by randomized command traffic.
module tb_ugv_motion_sequencer;

    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 64;
    localparam int DEADTIME    = 8;
    localparam int WDOG_CYCLES = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_speed = '0;
    logic [1:0] cmd_dir = '0;
    logic       cmd_ready;
    logic [7:0] duty;
    logic       in1, in2, in3, in4;
    logic       busy;
    logic       wdog_trip;

    ugv_motion_sequencer #(
        .RAMP_DIV   (RAMP_DIV),
        .RAMP_STEP  (RAMP_STEP),
        .DEADTIME   (DEADTIME),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed),
        .cmd_dir  (cmd_dir),
        .duty     (duty),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .busy     (busy),
        .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    // Visible behaviour after one clock edge.
    typedef struct {
        int duty;
        int dir;
        bit ready;
        bit busy;
    } snap_t;

    typedef struct packed {
        logic [7:0] duty;
        logic [3:0] pins;
        logic       ready;
        logic       busy;
        logic       trip;
    } obs_t;

    int    n_cmp  = 0;
    int    n_fail = 0;
    snap_t cur;
    snap_t plan[$];
    obs_t  expq[$];
    obs_t  last_exp;
    int    wd;
    bit    trip_m;
    int    acc_cnt = 0;

    function automatic snap_t mk(input int d, input int dir, input bit r, input bit b);
        snap_t s;
        s.duty = d; s.dir = dir; s.ready = r; s.busy = b;
        return s;
    endfunction

    function automatic int step_to(input int c, input int t);
        if (c < t) return (c + RAMP_STEP > t) ? t : c + RAMP_STEP;
        if (c > t) return (c - RAMP_STEP < t) ? t : c - RAMP_STEP;
        return c;
    endfunction

    function automatic logic [3:0] pins_of(input int dir);
        case (dir)
            1:       return 4'b1010;
            2:       return 4'b0110;
            3:       return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Plan a ramp from d to t in direction dir; the first entry is the accepting edge.
    task automatic plan_ramp(input int d, input int t, input int dir);
        int c = d;
        while (c != t) begin
            for (int j = 0; j < RAMP_DIV; j++) plan.push_back(mk(c, dir, 1'b1, 1'b1));
            c = step_to(c, t);
        end
        plan.push_back(mk(c, dir, 1'b1, 1'b1));
    endtask

    // Plan a brake to zero, the dead window, then either idle or the pending ramp.
    task automatic plan_brake(input int d, input int old_dir, input int pdir, input int pspd);
        int c = d;
        if (c == 0) plan.push_back(mk(0, old_dir, 1'b0, 1'b1));
        while (c != 0) begin
            for (int j = 0; j < RAMP_DIV; j++) plan.push_back(mk(c, old_dir, 1'b0, 1'b1));
            c = step_to(c, 0);
        end
        for (int k = 0; k < DEADTIME; k++) plan.push_back(mk(0, 0, 1'b0, 1'b1));
        if (pdir == 0) plan.push_back(mk(0, 0, 1'b1, 1'b0));
        else plan_ramp(0, pspd, pdir);
    endtask

    task automatic model_reset();
        cur = mk(0, 0, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(mk(0, 0, 1'b1, 1'b0));
        expq.delete();
        last_exp = '0;
        wd = 0;
        trip_m = 1'b0;
    endtask

    task automatic model_edge();
        obs_t e;
        int   d = int'(cmd_dir);
        int   s = int'(cmd_speed);
        if (cmd_valid && cur.ready) begin
            acc_cnt++;
            trip_m = 1'b0;
            wd = 0;
            plan.delete();
            if (d == 0) plan_brake(cur.duty, cur.dir, 0, 0);
            else if (d == cur.dir) plan_ramp(cur.duty, s, d);
            else if (cur.dir == 0 && cur.duty == 0) plan_ramp(0, s, d);
            else plan_brake(cur.duty, cur.dir, d, s);
        end else if (cur.ready && cur.dir != 0) begin
            wd++;
            if (wd == WDOG_CYCLES) begin
                trip_m = 1'b1;
                wd = 0;
                plan.delete();
                plan_brake(cur.duty, cur.dir, 0, 0);
            end
        end else begin
            wd = 0;
        end
        if (plan.size() > 0) cur = plan.pop_front();
        e.duty  = 8'(cur.duty);
        e.pins  = pins_of(cur.dir);
        e.ready = cur.ready;
        e.busy  = cur.busy;
        e.trip  = trip_m;
        expq.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!rst) model_edge();
    end

    // Monitor: compare every cycle's outputs with the next scoreboard entry.
    always @(negedge clk) begin
        obs_t act;
        obs_t exp;
        act = {duty, in1, in2, in3, in4, cmd_ready, busy, wdog_trip};
        if (rst) exp = '0;
        else if (expq.size() > 0) begin
            exp = expq.pop_front();
            last_exp = exp;
        end else exp = last_exp;
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle t=%0t got duty=%0d pins=%b rdy=%b busy=%b trip=%b want duty=%0d pins=%b rdy=%b busy=%b trip=%b",
                     $time, act.duty, act.pins, act.ready, act.busy, act.trip,
                     exp.duty, exp.pins, exp.ready, exp.busy, exp.trip);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    // Present a command and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [1:0] d, input logic [7:0] s);
        int base = acc_cnt;
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = d; cmd_speed = s;
        while (acc_cnt == base && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        check("send-accept", (acc_cnt != base) ? 1 : 0, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset();
        #3;
        cmd_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check("async-rst-duty", int'(duty), 0);
        check("async-rst-pins", int'({in1, in2, in3, in4}), 0);
        check("async-rst-ready", int'(cmd_ready), 0);
        check("async-rst-busy", int'(busy), 0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    int t1_duty[4] = '{64, 128, 192, 200};

    initial begin
        int pct;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset-ready", int'(cmd_ready), 0);
        check("reset-duty", int'(duty), 0);
        check("reset-busy", int'(busy), 0);
        #2 rst = 1'b0;

        // 1: forward ramp from idle
        send(2'b01, 8'd200);
        check("t1-pins", int'({in1, in2, in3, in4}), 4'b1010);
        check("t1-busy", int'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            repeat (RAMP_DIV) @(posedge clk);
            #1;
            check("t1-duty", int'(duty), t1_duty[k]);
        end
        idle(10);

        // 2: direction change with brake and dead time
        send(2'b10, 8'd128);
        idle(50);

        // 3: same-direction retarget mid-ramp
        send(2'b01, 8'd255);
        repeat (25) @(posedge clk);
        send(2'b01, 8'd100);
        idle(30);

        // 4: watchdog timeout
        send(2'b01, 8'd200);
        repeat (210) @(posedge clk);
        #1;
        check("t4-trip", int'(wdog_trip), 1);
        idle(40);

        // 5: reset during dead time, then restart without dead time
        send(2'b01, 8'd200);
        idle(20);
        send(2'b10, 8'd128);
        repeat (17) @(posedge clk);
        async_reset();
        send(2'b01, 8'd64);
        check("t5-pins", int'({in1, in2, in3, in4}), 4'b1010);
        idle(20);

        // 6: stop with ignored speed
        send(2'b11, 8'd255);
        idle(60);
        send(2'b00, 8'd77);
        idle(40);

        // randomized traffic at several command densities
        for (int blk = 0; blk < 4; blk++) begin
            case (blk)
                0:       pct = 3;
                1:       pct = 15;
                2:       pct = 0;
                default: pct = 1;
            endcase
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                if ($urandom_range(99, 0) < pct) begin
                    cmd_valid = 1'b1;
                    cmd_dir = 2'($urandom_range(3, 0));
                    case ($urandom_range(4, 0))
                        0:       cmd_speed = 8'd0;
                        1:       cmd_speed = 8'd255;
                        2:       cmd_speed = 8'd64;
                        3:       cmd_speed = 8'd128;
                        default: cmd_speed = 8'($urandom_range(255, 0));
                    endcase
                end else begin
                    cmd_valid = 1'b0;
                end
                if (blk == 1 && i == 400) async_reset();
            end
            if (blk == 1) begin
                send(2'b11, 8'd180);
            end
        end

        idle(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global-timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
